// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared constants, scoreboard op encoding and width helper
//               for the forwarding / scoreboard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

   localparam int FWD_NONE   = 0;
   localparam int PC_REG_DEF = 15;

   typedef enum logic [1:0] {
      SB_HOLD = 2'd0,
      SB_INC  = 2'd1,
      SB_DEC  = 2'd2,
      SB_CLR  = 2'd3
   } sb_op_e;

   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int k = 1; k < 31; k++) begin
         if ((1 << k) < v) r = k + 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_pick.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pick
// Description : Per-operand priority encoder over write-back producers,
//               returning forward select and hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_pick
   import fwd_pkg::*;
#(
   parameter int NUM_WB = 4,
   parameter int REG_AW = 4,
   parameter int PC_REG = PC_REG_DEF,
   parameter int SELW   = clog2(NUM_WB + 1)
) (
   input  logic [REG_AW-1:0]        i_src_addr,
   input  logic                     i_src_use,
   input  logic [NUM_WB*REG_AW-1:0] i_wb_addr,
   input  logic [NUM_WB-1:0]        i_wb_we,
   input  logic [NUM_WB-1:0]        i_wb_rdy,
   input  logic                     i_busy,
   output logic [SELW-1:0]          o_sel,
   output logic                     o_hazard
);

   localparam logic [REG_AW-1:0] c_pc_addr = REG_AW'(PC_REG);

   logic w_hit;

   // Youngest matching producer wins; an unready youngest match blocks older ones.
   always_comb begin
      o_sel    = SELW'(FWD_NONE);
      o_hazard = 1'b0;
      w_hit    = 1'b0;
      if (i_src_use && (i_src_addr != c_pc_addr)) begin
         for (int j = 0; j < NUM_WB; j++) begin
            if (!w_hit && i_wb_we[j] && (i_wb_addr[j*REG_AW +: REG_AW] == i_src_addr)) begin
               w_hit = 1'b1;
               if (i_wb_rdy[j]) o_sel    = SELW'(j + 1);
               else             o_hazard = 1'b1;
            end
         end
         if (!w_hit) o_hazard = i_busy;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fwd_sb_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sb_unit
// Description : Forwarding / hazard unit with pending-write scoreboard,
//               stall performance counter, stall watchdog and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sb_unit
   import fwd_pkg::*;
#(
   parameter int NUM_SRC  = 4,
   parameter int NUM_WB   = 4,
   parameter int REG_AW   = 4,
   parameter int PC_REG   = PC_REG_DEF,
   parameter int CNT_W    = 2,
   parameter int WDOG_CYC = 64
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_SRC*REG_AW-1:0]              i_src_addr,
   input  logic [NUM_SRC-1:0]                     i_src_use,
   input  logic [NUM_WB*REG_AW-1:0]               i_wb_addr,
   input  logic [NUM_WB-1:0]                      i_wb_we,
   input  logic [NUM_WB-1:0]                      i_wb_rdy,
   input  logic                                   i_iss_valid,
   input  logic [REG_AW-1:0]                      i_iss_addr,
   input  logic                                   i_ret_valid,
   input  logic [REG_AW-1:0]                      i_ret_addr,
   input  logic                                   i_sb_clear,
   output logic [NUM_SRC*clog2(NUM_WB+1)-1:0]     o_fwd_sel,
   output logic                                   o_stall,
   output logic [2**REG_AW-1:0]                   o_reg_busy,
   output logic [31:0]                            o_stall_cnt,
   output logic                                   o_wdog,
   output logic                                   o_sb_err
);

   localparam int SELW  = clog2(NUM_WB + 1);
   localparam int NREG  = 2**REG_AW;
   localparam int RUN_W = clog2(WDOG_CYC + 1);

   logic [NREG-1:0]    w_busy;
   logic [NREG-1:0]    w_err;
   logic [NUM_SRC-1:0] w_haz;
   logic [31:0]        r_stall_cnt;
   logic [RUN_W-1:0]   r_run;
   logic               r_wdog;
   logic               r_sb_err;

   generate
      for (genvar r = 0; r < NREG; r++) begin : g_reg
         if (r == PC_REG) begin : g_pc
            assign w_busy[r] = 1'b0;
            assign w_err[r]  = 1'b0;
         end else begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;
            sb_op_e           w_op;

            assign w_inc = i_iss_valid && (i_iss_addr == REG_AW'(r));
            assign w_dec = i_ret_valid && (i_ret_addr == REG_AW'(r));

            // Flush beats inc/dec; simultaneous inc and dec cancel.
            always_comb begin
               w_op = SB_HOLD;
               if (i_sb_clear)          w_op = SB_CLR;
               else if (w_inc && !w_dec) w_op = SB_INC;
               else if (w_dec && !w_inc) w_op = SB_DEC;
            end

            assign w_err[r]  = ((w_op == SB_INC) && (r_cnt == '1)) ||
                               ((w_op == SB_DEC) && (r_cnt == '0));
            assign w_busy[r] = |r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_cnt <= '0;
               end else begin
                  case (w_op)
                     SB_CLR:  r_cnt <= '0;
                     SB_INC:  if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
                     SB_DEC:  if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                     default: r_cnt <= r_cnt;
                  endcase
               end
            end
         end
      end

      for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
         fwd_pick #(
            .NUM_WB (NUM_WB),
            .REG_AW (REG_AW),
            .PC_REG (PC_REG),
            .SELW   (SELW)
         ) u_pick (
            .i_src_addr (i_src_addr[i*REG_AW +: REG_AW]),
            .i_src_use  (i_src_use[i]),
            .i_wb_addr  (i_wb_addr),
            .i_wb_we    (i_wb_we),
            .i_wb_rdy   (i_wb_rdy),
            .i_busy     (w_busy[i_src_addr[i*REG_AW +: REG_AW]]),
            .o_sel      (o_fwd_sel[i*SELW +: SELW]),
            .o_hazard   (w_haz[i])
         );
      end
   endgenerate

   assign o_stall = |w_haz;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_run       <= '0;
         r_wdog      <= 1'b0;
         r_sb_err    <= 1'b0;
      end else begin
         if (o_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (!o_stall)                            r_run <= '0;
         else if (r_run != RUN_W'(WDOG_CYC))      r_run <= r_run + 1'b1;
         // The run counter still holds the previous count here, hence the -1.
         if (o_stall && (r_run >= RUN_W'(WDOG_CYC - 1))) r_wdog <= 1'b1;
         if (|w_err) r_sb_err <= 1'b1;
      end
   end

   assign o_reg_busy  = w_busy;
   assign o_stall_cnt = r_stall_cnt;
   assign o_wdog      = r_wdog;
   assign o_sb_err    = r_sb_err;

endmodule
`default_nettype wire
